// File: rtl/voter_case.sv
// Four-voter majority block: decodes a 4-bit vote vector into a registered
// one-hot verdict (pass / tie / reject) with one cycle of latency.
module voter_case (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] I_tb,
  output logic [3:1] O_tb
);

  localparam logic [3:1] VERDICT_NONE   = 3'b000;
  localparam logic [3:1] VERDICT_PASS   = 3'b001;
  localparam logic [3:1] VERDICT_TIE    = 3'b010;
  localparam logic [3:1] VERDICT_REJECT = 3'b100;

  // Full truth table; an X/Z vote vector matches no item and falls to reject.
  function automatic logic [3:1] decode_verdict(input logic [3:0] votes);
    logic [3:1] verdict;
    verdict = VERDICT_REJECT;
    case (votes)
      4'b0000: verdict = VERDICT_REJECT;
      4'b0001: verdict = VERDICT_REJECT;
      4'b0010: verdict = VERDICT_REJECT;
      4'b0011: verdict = VERDICT_TIE;
      4'b0100: verdict = VERDICT_REJECT;
      4'b0101: verdict = VERDICT_TIE;
      4'b0110: verdict = VERDICT_TIE;
      4'b0111: verdict = VERDICT_PASS;
      4'b1000: verdict = VERDICT_REJECT;
      4'b1001: verdict = VERDICT_TIE;
      4'b1010: verdict = VERDICT_TIE;
      4'b1011: verdict = VERDICT_PASS;
      4'b1100: verdict = VERDICT_TIE;
      4'b1101: verdict = VERDICT_PASS;
      4'b1110: verdict = VERDICT_PASS;
      4'b1111: verdict = VERDICT_PASS;
      default: verdict = VERDICT_REJECT;
    endcase
    return verdict;
  endfunction

  logic [3:1] verdict_p1;

  // Stage p1: verdict register, the only state in the block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      verdict_p1 <= VERDICT_NONE;
    end else begin
      verdict_p1 <= decode_verdict(I_tb);
    end
  end

  assign O_tb = verdict_p1;

endmodule

// File: tb/tb_voter_case.sv
// Directed bench for voter_case: reset, exhaustive vote sweep, back-to-back
// changes, mid-stream reset and between-edge reset pulses.
module tb_voter_case;

  logic       clk;
  logic       rst_n;
  logic [3:0] I_tb;
  logic [3:1] O_tb;

  int n_cmp;
  int n_bad;

  voter_case dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I_tb  (I_tb),
    .O_tb  (O_tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written expected verdicts indexed by vote code
  logic [3:1] exp_tab [16];
  initial begin
    exp_tab[0]  = 3'b100; exp_tab[1]  = 3'b100; exp_tab[2]  = 3'b100; exp_tab[3]  = 3'b010;
    exp_tab[4]  = 3'b100; exp_tab[5]  = 3'b010; exp_tab[6]  = 3'b010; exp_tab[7]  = 3'b001;
    exp_tab[8]  = 3'b100; exp_tab[9]  = 3'b010; exp_tab[10] = 3'b010; exp_tab[11] = 3'b001;
    exp_tab[12] = 3'b010; exp_tab[13] = 3'b001; exp_tab[14] = 3'b001; exp_tab[15] = 3'b001;
  end

  task automatic check_eq(input string tag, input logic [3:1] got, input logic [3:1] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariant checks: one-hot after a non-reset edge, and no change between edges
  logic       rst_q = 1'b0;
  logic [3:1] o_snap;
  always @(posedge clk) rst_q <= rst_n;
  always @(posedge clk) begin
    #1 o_snap = O_tb;
  end
  always @(negedge clk) begin
    if (rst_q) assert ($onehot(O_tb)) else $error("verdict not one-hot: %b", O_tb);
    if ($time > 20) assert (O_tb === o_snap) else $error("verdict changed between edges");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    I_tb  = 4'b1111;

    tick();
    check_eq("reset_edge1", O_tb, 3'b000);
    tick();
    check_eq("reset_edge2", O_tb, 3'b000);
    rst_n = 1'b1;
    tick();
    check_eq("reset_release", O_tb, 3'b001);

    for (int i = 0; i < 16; i++) begin
      I_tb = 4'(i);
      tick();
      check_eq($sformatf("sweep_%b", I_tb), O_tb, exp_tab[i]);
    end

    I_tb = 4'b0000;
    tick();
    check_eq("b2b_0000", O_tb, 3'b100);
    I_tb = 4'b1111;
    tick();
    check_eq("b2b_1111", O_tb, 3'b001);
    I_tb = 4'b0011;
    tick();
    check_eq("b2b_0011", O_tb, 3'b010);

    I_tb = 4'b0111;
    tick();
    check_eq("mid_pre", O_tb, 3'b001);
    rst_n = 1'b0;
    tick();
    check_eq("mid_reset", O_tb, 3'b000);
    rst_n = 1'b1;
    tick();
    check_eq("mid_release", O_tb, 3'b001);

    I_tb = 4'b0011;
    tick();
    check_eq("sync_pre", O_tb, 3'b010);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    check_eq("sync_between", O_tb, 3'b010);
    tick();
    check_eq("sync_after", O_tb, 3'b010);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check_eq("sync_after2", O_tb, 3'b010);

    I_tb = 4'b1000;
    tick();
    check_eq("final_1000", O_tb, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
